monitor_spi_master: RTL

- SPI master that reads the board Monitor's address/data snapshot over its SPI slave port (SPICLK, SPISS_n, SPISO).
- Generates SPICLK and SPISS_n and shifts in one 40-bit frame per request: ADDR[23:0] then DATA[15:0], MSB first.
- Presents the captured frame in parallel with a one-cycle VALID strobe.
- Used in the debug/host-bridge FPGA and in simulation as the far end of the Monitor link.

---
 rtl/monitor_spi_master.sv | 108 ++++++++++
 1 files changed

// File: rtl/monitor_spi_master.sv
// SPI mode-0 master that pulls one 40-bit {ADDR[23:0], DATA[15:0]} snapshot from the
// board Monitor per START request and presents it in parallel with a one-cycle VALID.
module monitor_spi_master #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic        MCLK,
    input  logic        RESET_n,
    input  logic        START,
    input  logic        SPISO,
    output logic        SPICLK,
    output logic        SPISS_n,
    output logic        BUSY,
    output logic        VALID,
    output logic [23:0] ADDR_OUT,
    output logic [15:0] DATA_OUT
);

    localparam int unsigned DivW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);
    localparam logic [5:0] FrameBits = 6'd40;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShiftLo,
        StShiftHi,
        StHold,
        StGap
    } state_e;

    state_e          state_q;
    logic [DivW-1:0] div_q;
    logic [5:0]      bit_cnt_q;
    logic [39:0]     shift_q;
    logic            div_last;

    assign div_last = (div_q == DivLast);

    always_ff @(posedge MCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= StIdle;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            SPICLK    <= 1'b0;
            SPISS_n   <= 1'b1;
            BUSY      <= 1'b0;
            VALID     <= 1'b0;
            ADDR_OUT  <= '0;
            DATA_OUT  <= '0;
        end else begin
            VALID <= 1'b0;
            // Every non-idle phase lasts exactly CLKDIV cycles; the divider wraps on its last one.
            if (state_q != StIdle) begin
                div_q <= div_last ? '0 : div_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q   <= StSetup;
                        SPISS_n   <= 1'b0;
                        BUSY      <= 1'b1;
                        div_q     <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                StSetup: begin
                    if (div_last) begin
                        state_q <= StShiftLo;
                    end
                end
                StShiftLo: begin
                    if (div_last) begin
                        SPICLK    <= 1'b1;
                        shift_q   <= {shift_q[38:0], SPISO};
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        state_q   <= StShiftHi;
                    end
                end
                StShiftHi: begin
                    if (div_last) begin
                        SPICLK  <= 1'b0;
                        state_q <= (bit_cnt_q == FrameBits) ? StHold : StShiftLo;
                    end
                end
                StHold: begin
                    if (div_last) begin
                        SPISS_n  <= 1'b1;
                        ADDR_OUT <= shift_q[39:16];
                        DATA_OUT <= shift_q[15:0];
                        VALID    <= 1'b1;
                        state_q  <= StGap;
                    end
                end
                StGap: begin
                    if (div_last) begin
                        BUSY    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
